// File: rtl/lsu_ctrl.sv
// Load/store unit controller: issues one data-memory access per instruction,
// aligns store lanes, extends load data and reports misalignment and bus timeouts.
module lsu_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_be,
   output logic [31:0] mem_wdata,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic [31:0] rd_data,
   output logic        rd_valid,
   output logic        misalign,
   output logic        bus_err,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e      state, state_nxt;
   logic        lat_we;
   logic [2:0]  lat_f3;
   logic [31:0] lat_addr, lat_wdata;
   logic [7:0]  wait_cnt;
   logic        fault_q, err_q, ok_q;
   logic [31:0] rd_data_q;

   logic        req_fault, timeout;
   logic [3:0]  be_lanes;
   logic [31:0] wdata_lanes, load_ext;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Handshake: mem_req/mem_we/mem_addr/mem_be/mem_wdata are held stable from the
   // first REQ cycle until the cycle mem_ready is sampled high (or timeout fires).
   assign req_fault = (funct3 == 3'b011) || (funct3[2:1] == 2'b11)
                    || ((funct3[1:0] == 2'b01) && addr[0])
                    || ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
   assign timeout   = (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_valid) state_nxt = req_fault ? RESP : REQ;
         REQ:     if (mem_ready || timeout) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      be_lanes    = 4'b1111;
      wdata_lanes = lat_wdata;
      case (lat_f3[1:0])
         2'b00: begin
            be_lanes    = 4'b0001 << lat_addr[1:0];
            wdata_lanes = {4{lat_wdata[7:0]}};
         end
         2'b01: begin
            be_lanes    = lat_addr[1] ? 4'b1100 : 4'b0011;
            wdata_lanes = {2{lat_wdata[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      byte_sel = mem_rdata[{lat_addr[1:0], 3'b000} +: 8];
      half_sel = lat_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
      case (lat_f3)
         3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_ext = {24'd0, byte_sel};
         3'b101:  load_ext = {16'd0, half_sel};
         default: load_ext = mem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         lat_we    <= 1'b0;
         lat_f3    <= 3'd0;
         lat_addr  <= 32'd0;
         lat_wdata <= 32'd0;
         wait_cnt  <= 8'd0;
         fault_q   <= 1'b0;
         err_q     <= 1'b0;
         ok_q      <= 1'b0;
         rd_data_q <= 32'd0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: if (req_valid) begin
               lat_we    <= req_we;
               lat_f3    <= funct3;
               lat_addr  <= addr;
               lat_wdata <= wdata;
               wait_cnt  <= 8'd0;
               fault_q   <= req_fault;
               err_q     <= 1'b0;
               ok_q      <= 1'b0;
            end
            REQ: begin
               // A late mem_ready on the timeout cycle still completes the access.
               if (mem_ready) begin
                  ok_q <= !lat_we;
                  if (!lat_we) rd_data_q <= load_ext;
               end else if (timeout) begin
                  err_q     <= 1'b1;
                  rd_data_q <= 32'd0;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            RESP: begin
               fault_q <= 1'b0;
               err_q   <= 1'b0;
               ok_q    <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign mem_req   = (state == REQ);
   assign mem_we    = mem_req && lat_we;
   assign mem_addr  = {lat_addr[31:2], 2'b00};
   assign mem_be    = mem_req ? be_lanes : 4'b0000;
   assign mem_wdata = mem_we ? wdata_lanes : 32'd0;
   assign stall     = rst_n && ((state == IDLE) ? req_valid : (state == REQ));
   assign rd_data   = rd_data_q;
   assign rd_valid  = (state == RESP) && ok_q;
   assign misalign  = (state == RESP) && fault_q;
   assign bus_err   = (state == RESP) && err_q;
   assign state_dbg = state;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomised bench for lsu_ctrl: each access is predicted from the size/sign/
// alignment rules and checked cycle by cycle against the memory-side handshake.
module tb_lsu_ctrl;

   localparam int TMO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_we, mem_ready;
   logic [2:0]  funct3;
   logic [31:0] addr, wdata, mem_rdata;
   logic        stall, mem_req, mem_we, rd_valid, misalign, bus_err;
   logic [31:0] mem_addr, mem_wdata, rd_data;
   logic [3:0]  mem_be;
   logic [1:0]  state_dbg;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          first_req_cyc = 0;
   int          stall_seen = 0;
   logic [31:0] model_rd = 32'd0;
   logic [31:0] exp_q[$];

   lsu_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
      .funct3(funct3), .addr(addr), .wdata(wdata), .stall(stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .rd_data(rd_data), .rd_valid(rd_valid), .misalign(misalign),
      .bus_err(bus_err), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic is_fault(input logic [2:0] f3, input logic [31:0] a);
      int bytes;
      if (!(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b1;
      bytes = 1 << f3[1:0];
      return (a % bytes) != 0;
   endfunction

   function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
      int bytes, lane;
      logic [3:0] be;
      bytes = 1 << f3[1:0];
      lane  = int'(a[1:0]);
      be = 4'd0;
      for (int i = 0; i < bytes; i++) be[lane + i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] wd);
      case (f3[1:0])
         2'd0:    return wd[7:0] * 32'h0101_0101;
         2'd1:    return wd[15:0] * 32'h0001_0001;
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] rd);
      logic [31:0] sh;
      sh = rd >> (int'(a[1:0]) * 8);
      case (f3)
         3'd0:    return (sh[7] ? 32'hFFFF_FF00 : 32'd0) | (sh & 32'hFF);
         3'd1:    return (sh[15] ? 32'hFFFF_0000 : 32'd0) | (sh & 32'hFFFF);
         3'd4:    return sh & 32'hFF;
         3'd5:    return sh & 32'hFFFF;
         default: return rd;
      endcase
   endfunction

   task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rdat, input int wait_n);
      logic fault, timed_out, ok;
      fault     = is_fault(f3, a);
      timed_out = 1'b0;
      @(posedge clk); #1;
      chk("idle_rd_valid", rd_valid, 0);
      chk("idle_rd_hold", rd_data, model_rd);
      req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd; mem_ready = 1'b0;
      #1;
      chk("idle_stall", stall, 1);
      chk("idle_mem_req", mem_req, 0);
      stall_seen = 1;
      if (!fault) begin
         for (int k = 0; k <= TMO; k++) begin
            @(posedge clk); #1;
            req_valid = 1'($urandom_range(0, 1)); req_we = 1'($urandom);
            funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
            mem_ready = (k == wait_n);
            mem_rdata = (k == wait_n) ? rdat : $urandom;
            #1;
            if (k == 0) first_req_cyc = cyc;
            chk("req_mem_req", mem_req, 1);
            chk("req_stall", stall, stall ? 1 : 0);
            if (stall) stall_seen++;
            else chk("req_stall_hi", stall, 1);
            chk("req_mem_we", mem_we, we);
            chk("req_mem_addr", mem_addr, a & 32'hFFFF_FFFC);
            chk("req_mem_be", mem_be, exp_be(f3, a));
            chk("req_mem_wdata", mem_wdata, we ? exp_wd(f3, wd) : 32'd0);
            if (k == wait_n) break;
            if (k == TMO - 1) begin timed_out = 1'b1; break; end
         end
         if (timed_out) model_rd = 32'd0;
         else if (!we) model_rd = exp_load(f3, a, rdat);
      end
      exp_q.push_back(model_rd);
      ok = !fault && !timed_out && !we;
      @(posedge clk); #1;
      mem_ready = 1'b0; req_valid = 1'($urandom_range(0, 1)); funct3 = 3'($urandom); addr = $urandom;
      #1;
      chk("resp_stall", stall, 0);
      chk("resp_mem_req", mem_req, 0);
      chk("resp_misalign", misalign, fault);
      chk("resp_bus_err", bus_err, timed_out);
      chk("resp_rd_valid", rd_valid, ok);
      chk("resp_rd_data", rd_data, exp_q.pop_front());
   endtask

   initial begin
      int f1;
      logic [2:0] f3;
      logic [31:0] a;
      rst_n = 1'b0; req_valid = 1'b1; req_we = 1'b0; funct3 = 3'd0; addr = 32'd0;
      wdata = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stall", stall, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_flags", {rd_valid, misalign, bus_err, mem_we}, 0);
      rst_n = 1'b1; req_valid = 1'b0;

      do_op(1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_FF00, 2);
      chk("lb_stall_cycles", stall_seen, 4);
      chk("lb_value", model_rd, 32'hFFFF_FF80);
      do_op(1'b1, 3'b001, 32'h22, 32'h0000_BEEF, 32'd0, 0);
      do_op(1'b0, 3'b010, 32'h41, 32'd0, 32'd0, 0);
      do_op(1'b0, 3'b101, 32'h42, 32'd0, 32'h8001_0000, 0);
      chk("lhu_value", model_rd, 32'h0000_8001);
      do_op(1'b0, 3'b010, 32'h40, 32'd0, 32'h1234_5678, 1000);
      do_op(1'b0, 3'b010, 32'h40, 32'd0, 32'h1234_5678, TMO - 1);
      do_op(1'b0, 3'b011, 32'h80, 32'd0, 32'd0, 0);
      do_op(1'b0, 3'b010, 32'h100, 32'd0, 32'hCAFE_F00D, 0);
      f1 = first_req_cyc;
      do_op(1'b0, 3'b010, 32'h104, 32'd0, 32'hDEAD_BEEF, 0);
      chk("b2b_gap", first_req_cyc - f1, 3);

      // Reset in the middle of a request, with mem_ready colliding on the same edge.
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b0; funct3 = 3'b010; addr = 32'h200; mem_ready = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
      #1;
      chk("rstreq_mem_req_before", mem_req, 1);
      @(posedge clk); #1;
      mem_ready = 1'b0;
      #1;
      chk("rstreq_stall_low", stall, 0);
      chk("rstreq_mem_req", mem_req, 0);
      chk("rstreq_pulses", {rd_valid, misalign, bus_err}, 0);
      chk("rstreq_rd_data", rd_data, 0);
      model_rd = 32'd0;
      rst_n = 1'b1; req_valid = 1'b0;
      @(posedge clk); #1;
      chk("rstreq_after", {mem_req, rd_valid, misalign, bus_err}, 0);

      for (int i = 0; i < 80; i++) begin
         f3 = 3'($urandom);
         a = $urandom;
         if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << f3[1:0]) - 32'd1);
         do_op(1'($urandom), f3, a, $urandom, $urandom,
               ($urandom_range(0, 7) == 0) ? $urandom_range(TMO - 2, TMO + 2) : $urandom_range(0, 3));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
